// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- instruction fetch unit with a two-entry instruction buffer.
//
// Issues word-address fetches to instruction memory (at most one live request),
// buffers the returned words and presents the oldest one to decode. Returned
// words are predecoded so that an unconditional branch retargets the fetch PC
// and a HALT word stops further fetching. A downstream redirect flushes the
// buffer, restarts fetch at the new PC and discards responses still in flight.
//
// Ports
//   clk             clock, all state on the rising edge
//   reset_n         asynchronous active-low reset
//   imem_req        fetch request strobe (one cycle per request)
//   imem_addr       word address of the request (0 when no request)
//   imem_valid      response strobe from instruction memory
//   imem_data       response instruction word
//   Instruction     buffer head word
//   instr_pc        word address of Instruction
//   instr_valid     Instruction / instr_pc are valid
//   instr_ready     decode accepts the head this cycle
//   redirect_valid  flush and refetch from redirect_pc
//   redirect_pc     redirect target word address
//   halted          fetch stopped after the HALT word was accepted
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  output logic [31:0] Instruction,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        halted
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e      state_q, state_d, st_eff;
  logic [15:0] pc_q, pc_d, pc_eff;
  logic [15:0] req_pc_q, req_pc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  disc_q, disc_d;
  logic [31:0] data0_q, data0_d, data1_q, data1_d;
  logic [15:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic        halted_q, halted_d;

  logic        is_b, is_halt;
  logic        resp_ok, resp_drop, push, pop, issue;
  logic [1:0]  occ, wr_idx;
  logic [2:0]  live;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    cnt_d    = cnt_q;
    disc_d   = disc_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    pc0_d    = pc0_q;
    pc1_d    = pc1_q;
    halted_d = halted_q;
    st_eff   = state_q;
    pc_eff   = pc_q;
    live     = 3'd0;

    is_b    = (imem_data[31:25] == 7'b1100000);
    is_halt = (imem_data[31:30] == 2'b11) && imem_data[28] && !imem_data[27];

    // disc_q counts responses still in flight that belong to a flushed stream;
    // memory answers in order, so the next disc_q responses are the stale ones.
    resp_drop = imem_valid && (disc_q != 2'd0);
    resp_ok   = imem_valid && (disc_q == 2'd0) && (state_q == S_WAIT) && !redirect_valid;

    pop  = (cnt_q != 2'd0) && instr_ready && !redirect_valid;
    push = resp_ok && ((cnt_q != DEPTH) || pop);

    // A returning response frees the request slot in the same cycle, so the
    // issue decision works from the post-response state and PC.
    if (resp_ok) begin
      st_eff = is_halt ? S_HALT : S_RUN;
      if (is_b) begin
        pc_eff = req_pc_q + imem_data[15:0];
      end
    end

    occ   = cnt_q + {1'b0, push} - {1'b0, pop};
    issue = !redirect_valid && (st_eff == S_RUN) && (occ < DEPTH);

    state_d  = issue ? S_WAIT : st_eff;
    pc_d     = issue ? (pc_eff + 16'd1) : pc_eff;
    req_pc_d = issue ? pc_eff : req_pc_q;
    cnt_d    = occ;
    disc_d   = disc_q - {1'b0, resp_drop};

    // HALT is always the last word fetched, so popping the final entry while
    // in HALT is the acceptance of the HALT word itself.
    if ((state_q == S_HALT) && pop && (cnt_q == 2'd1)) begin
      halted_d = 1'b1;
    end

    // Head is always entry 0; a pop shifts entry 1 down, a push fills the
    // first free slot after that shift.
    if (pop) begin
      data0_d = data1_q;
      pc0_d   = pc1_q;
    end
    wr_idx = cnt_q - {1'b0, pop};
    if (push) begin
      if (wr_idx == 2'd0) begin
        data0_d = imem_data;
        pc0_d   = req_pc_q;
      end else begin
        data1_d = imem_data;
        pc1_d   = req_pc_q;
      end
    end

    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response arriving in the
      // redirect cycle itself is one of them and is consumed here.
      live = 3'(disc_q) + ((state_q == S_WAIT) ? 3'd1 : 3'd0);
      if (imem_valid && (live != 3'd0)) begin
        live = live - 3'd1;
      end
      disc_d   = (live > 3'd3) ? 2'd3 : live[1:0];
      cnt_d    = 2'd0;
      state_d  = S_RUN;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      req_pc_q <= 16'h0000;
      cnt_q    <= 2'd0;
      disc_q   <= 2'd0;
      data0_q  <= 32'h0000_0000;
      data1_q  <= 32'h0000_0000;
      pc0_q    <= 16'h0000;
      pc1_q    <= 16'h0000;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      cnt_q    <= cnt_d;
      disc_q   <= disc_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      pc0_q    <= pc0_d;
      pc1_q    <= pc1_d;
      halted_q <= halted_d;
    end
  end

  // The request is combinational, so it is gated by reset_n to stay low while
  // reset is held even though the state register already reads RUN.
  assign imem_req    = issue && reset_n;
  assign imem_addr   = (issue && reset_n) ? pc_eff : 16'h0000;
  assign Instruction = data0_q;
  assign instr_pc    = pc0_q;
  assign instr_valid = (cnt_q != 2'd0);
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch -- directed bench for instr_fetch.
// A behavioural instruction memory with programmable latency answers dut0
// (RESET_PC=0); dut1 (RESET_PC=FFFF) is fed by hand for the wrap case.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        reset_n;
  logic        imem_req, imem_req1;
  logic [15:0] imem_addr, imem_addr1;
  logic        imem_valid, imem_valid1;
  logic [31:0] imem_data, imem_data1;
  logic [31:0] Instruction, Instruction1;
  logic [15:0] instr_pc, instr_pc1;
  logic        instr_valid, instr_valid1;
  logic        instr_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halted, halted1;

  int checks;
  int failures;

  instr_fetch #(.RESET_PC(16'h0000), .BUF_DEPTH(2)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .Instruction(Instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  instr_fetch #(.RESET_PC(16'hFFFF), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req1), .imem_addr(imem_addr1),
    .imem_valid(imem_valid1), .imem_data(imem_data1),
    .Instruction(Instruction1), .instr_pc(instr_pc1), .instr_valid(instr_valid1),
    .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instruction memory model ----------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } req_t;

  req_t        q[$];
  int          cyc;
  int          mem_lat;
  logic        ov_en;
  logic [15:0] ov_addr;
  logic [31:0] ov_data;

  function automatic logic [31:0] mdata(input logic [15:0] a);
    if (ov_en && (a == ov_addr)) return ov_data;
    return {16'h1234, a};
  endfunction

  initial begin
    imem_valid = 1'b0;
    imem_data  = 32'h0;
    cyc        = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      imem_valid = 1'b0;
      if (reset_n && (q.size() > 0) && (q[0].due <= cyc)) begin
        imem_valid = 1'b1;
        imem_data  = mdata(q[0].addr);
        void'(q.pop_front());
      end
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        imem_valid = 1'b0;
      end else if (imem_req) begin
        q.push_back('{addr: imem_addr, due: cyc + mem_lat});
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    imem_valid1    = 1'b0;
    nxt();
    nxt();
    reset_n = 1'b1;
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    checks         = 0;
    failures       = 0;
    mem_lat        = 1;
    ov_en          = 1'b0;
    ov_addr        = 16'h0;
    ov_data        = 32'h0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    imem_valid1    = 1'b0;
    imem_data1     = 32'h0000_0000;
    reset_n        = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", Instruction, 32'd0);
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // Sequential stream, 1-cycle memory, decode always ready
    mem_lat = 1;
    do_reset();
    instr_ready = 1'b1;
    #1;
    chk("seq_req0", 32'(imem_req), 32'd1);
    chk("seq_addr0", 32'(imem_addr), 32'h0000);
    nxt(); #1;
    chk("seq_addr1", 32'(imem_addr), 32'h0001);
    chk("seq_nvalid1", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      nxt(); #1;
      chk("seq_valid", 32'(instr_valid), 32'd1);
      chk("seq_pc", 32'(instr_pc), 32'(i));
      chk("seq_instr", Instruction, {16'h1234, 16'(i)});
    end

    // Backpressure: two words buffered, no requests, head stable, then drain
    do_reset();
    #1;
    nxt(); #1;
    nxt(); #1;
    chk("bp_valid2", 32'(instr_valid), 32'd1);
    chk("bp_noreq2", 32'(imem_req), 32'd0);
    for (int k = 3; k <= 10; k++) begin
      nxt(); #1;
      chk("bp_noreq", 32'(imem_req), 32'd0);
      chk("bp_headpc", 32'(instr_pc), 32'h0000);
      chk("bp_headinstr", Instruction, 32'h1234_0000);
    end
    nxt();
    instr_ready = 1'b1;
    #1;
    chk("bp_drain0", 32'(instr_pc), 32'h0000);
    chk("bp_refill_req", 32'(imem_req), 32'd1);
    chk("bp_refill_addr", 32'(imem_addr), 32'h0002);
    nxt(); #1;
    chk("bp_drain1", 32'(instr_pc), 32'h0001);
    nxt(); #1;
    chk("bp_drain2", 32'(instr_pc), 32'h0002);

    // Predecoded unconditional branch at 0x0004, imm 0x0010
    ov_en   = 1'b1;
    ov_addr = 16'h0004;
    ov_data = 32'hC000_0010;
    do_reset();
    instr_ready = 1'b1;
    #1;
    for (int i = 1; i <= 4; i++) begin
      nxt(); #1;
    end
    chk("b_addr4", 32'(imem_addr), 32'h0004);
    nxt(); #1;
    chk("b_req_tgt", 32'(imem_req), 32'd1);
    chk("b_addr_tgt", 32'(imem_addr), 32'h0014);
    nxt(); #1;
    chk("b_deliver_pc", 32'(instr_pc), 32'h0004);
    chk("b_deliver_instr", Instruction, 32'hC000_0010);
    nxt(); #1;
    chk("b_next_pc", 32'(instr_pc), 32'h0014);
    chk("b_next_instr", Instruction, 32'h1234_0014);
    ov_en = 1'b0;

    // Redirect with a request in flight, 3-cycle memory
    mem_lat = 3;
    do_reset();
    instr_ready = 1'b1;
    #1;
    chk("rd_req0", 32'(imem_addr), 32'h0000);
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    #1;
    chk("rd_noreq_redir", 32'(imem_req), 32'd0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("rd_req_new", 32'(imem_req), 32'd1);
    chk("rd_addr_new", 32'(imem_addr), 32'h0100);
    nxt(); #1;
    chk("rd_drop3", 32'(instr_valid), 32'd0);
    nxt(); #1;
    chk("rd_drop4", 32'(instr_valid), 32'd0);
    nxt(); #1;
    chk("rd_empty5", 32'(instr_valid), 32'd0);
    chk("rd_addr_next", 32'(imem_addr), 32'h0101);
    nxt(); #1;
    chk("rd_valid6", 32'(instr_valid), 32'd1);
    chk("rd_pc6", 32'(instr_pc), 32'h0100);
    chk("rd_instr6", Instruction, 32'h1234_0100);

    // HALT word at 0x0002, then redirect to 0x0000
    mem_lat = 1;
    ov_en   = 1'b1;
    ov_addr = 16'h0002;
    ov_data = 32'hD000_0000;
    do_reset();
    instr_ready = 1'b1;
    #1;
    nxt(); #1;
    nxt(); #1;
    chk("h_addr2", 32'(imem_addr), 32'h0002);
    nxt(); #1;
    chk("h_noreq3", 32'(imem_req), 32'd0);
    nxt(); #1;
    chk("h_pc4", 32'(instr_pc), 32'h0002);
    chk("h_instr4", Instruction, 32'hD000_0000);
    chk("h_nhalt4", 32'(halted), 32'd0);
    nxt(); #1;
    chk("h_halted5", 32'(halted), 32'd1);
    chk("h_empty5", 32'(instr_valid), 32'd0);
    chk("h_noreq5", 32'(imem_req), 32'd0);
    nxt(); #1;
    chk("h_noreq6", 32'(imem_req), 32'd0);
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0000;
    #1;
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("h_clear", 32'(halted), 32'd0);
    chk("h_resume_req", 32'(imem_req), 32'd1);
    chk("h_resume_addr", 32'(imem_addr), 32'h0000);
    ov_en = 1'b0;

    // PC wrap on the RESET_PC=FFFF instance
    do_reset();
    #1;
    chk("w_req0", 32'(imem_req1), 32'd1);
    chk("w_addr0", 32'(imem_addr1), 32'hFFFF);
    nxt();
    imem_valid1 = 1'b1;
    #1;
    chk("w_req1", 32'(imem_req1), 32'd1);
    chk("w_addr1", 32'(imem_addr1), 32'h0000);
    nxt();
    imem_valid1 = 1'b0;

    // Reset asserted while a request is outstanding and the buffer holds data
    mem_lat = 1;
    do_reset();
    #1;
    nxt(); #1;
    nxt(); #1;
    chk("mr_valid_pre", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_addr", 32'(imem_addr), 32'd0);
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_instr", Instruction, 32'd0);
    chk("mr_pc", 32'(instr_pc), 32'd0);
    chk("mr_halted", 32'(halted), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
